fb_write_arbiter: RTL

Parametrised N-channel write arbiter for framebuffer BRAM port A. It merges writers onto the single write port: pattern generator, UART com_to_mem, and the upcoming Mandelbrot compute engines. Each channel has a one-entry holding register with a valid/ready handshake, and the block supports round-robin or fixed-priority arbitration. It adds address range checking with a drop counter and a built-in full-frame clear sweep.

---
 rtl/fb_write_arbiter.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
// ---------------------------------------------------------------------------
// fb_write_arbiter
//
// Merges several framebuffer writers (pattern generator, UART loader, compute
// engines, ...) onto the single write port A of the framebuffer BRAM.
//
// Every channel owns a one-entry holding register behind a valid/ready
// handshake. Held requests are granted one per enabled cycle, either
// round-robin (MODE 0) or by fixed priority with channel 0 highest (MODE 1).
// Requests whose address falls outside the framebuffer are accepted but
// discarded, and they are counted in a saturating drop counter. A clear
// pulse starts a sweep that fills the whole frame with one colour. Channel
// writes wait until the sweep has finished.
//
// Ports
//   clk, reset     system clock, synchronous active-high reset
//   i_enable       clock enable; grants and clear steps happen only when it is 1
//   i_valid        per-channel request valid
//   o_ready        per-channel holding register empty
//   i_addr/i_data  per-channel address/pixel, channel k at [k*W +: W]
//   i_clear        starts a full-frame clear (ignored while a clear runs)
//   i_clear_color  fill colour, sampled when the clear starts
//   o_we/o_addr/o_data  BRAM port A write strobe, address and data
//   o_grant_ch     channel of the current write (0 during a clear)
//   o_busy         high while the clear sweep runs
//   o_drop_cnt     saturating count of out-of-range requests
// ---------------------------------------------------------------------------
module fb_write_arbiter #(
    parameter int CHANNELS   = 4,
    parameter int CH_W       = 2,
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 76_800,
    parameter int MODE       = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_enable,
    input  logic [CHANNELS-1:0]              i_valid,
    output logic [CHANNELS-1:0]              o_ready,
    input  logic [CHANNELS*ADDR_WIDTH-1:0]   i_addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   i_data,
    input  logic                             i_clear,
    input  logic [DATA_WIDTH-1:0]            i_clear_color,
    output logic                             o_we,
    output logic [ADDR_WIDTH-1:0]            o_addr,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic [CH_W-1:0]                  o_grant_ch,
    output logic                             o_busy,
    output logic [15:0]                      o_drop_cnt
);

    // One extra bit so that a count of CHANNELS simultaneous drops fits.
    localparam int CNT_W = CH_W + 1;

    // DEPTH may equal 2**ADDR_WIDTH, so the range check is one bit wider
    // than the address.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------
    state_t                  state_reg, state_next;

    logic                    we_reg, we_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   data_reg, data_next;
    logic [CH_W-1:0]         grant_ch_reg, grant_ch_next;
    logic                    busy_reg, busy_next;
    logic [15:0]             drop_cnt_reg, drop_cnt_next;

    logic [ADDR_WIDTH-1:0]   clr_cnt_reg, clr_cnt_next;
    logic [DATA_WIDTH-1:0]   clr_color_reg, clr_color_next;
    logic [CH_W-1:0]         rr_ptr_reg, rr_ptr_next;

    logic [ADDR_WIDTH-1:0]   ch_addr   [CHANNELS];
    logic [DATA_WIDTH-1:0]   ch_data   [CHANNELS];
    logic [ADDR_WIDTH-1:0]   hold_addr [CHANNELS];
    logic [DATA_WIDTH-1:0]   hold_data [CHANNELS];
    logic [CHANNELS-1:0]     hold_valid;
    logic [CHANNELS-1:0]     accept;
    logic [CHANNELS-1:0]     in_range;
    logic [CHANNELS-1:0]     drop;

    logic                    grant_valid;
    logic [CH_W-1:0]         grant_idx;
    logic                    grant_fire;

    logic [CNT_W-1:0]        drop_total;
    logic [16:0]             drop_sum;

    // -----------------------------------------------------------------------
    // Per-channel holding registers
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic                  valid_reg;
            logic [ADDR_WIDTH-1:0] addr_reg_h;
            logic [DATA_WIDTH-1:0] data_reg_h;

            assign ch_addr[gi] = i_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign ch_data[gi] = i_data[gi*DATA_WIDTH +: DATA_WIDTH];

            // The handshake completes whenever the hold is empty, even during
            // a clear; only granting is suspended.
            assign accept[gi]   = i_valid[gi] & ~valid_reg;
            assign in_range[gi] = ({1'b0, ch_addr[gi]} < DEPTH_EXT);
            // Out-of-range requests are acknowledged but never stored, so the
            // writer is not stalled by a bad address.
            assign drop[gi]     = accept[gi] & ~in_range[gi];

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                end else if (accept[gi] && in_range[gi]) begin
                    valid_reg <= 1'b1;
                end else if (grant_fire && (grant_idx == CH_W'(gi))) begin
                    valid_reg <= 1'b0;
                end
            end

            // Payload needs no reset: it is only read while valid_reg is set.
            always_ff @(posedge clk) begin
                if (accept[gi] && in_range[gi]) begin
                    addr_reg_h <= ch_addr[gi];
                    data_reg_h <= ch_data[gi];
                end
            end

            assign hold_valid[gi] = valid_reg;
            assign hold_addr[gi]  = addr_reg_h;
            assign hold_data[gi]  = data_reg_h;
            assign o_ready[gi]    = ~valid_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Channel selection
    // -----------------------------------------------------------------------
    // Both searches walk the candidates from lowest to highest precedence so
    // that the last hit, i.e. the highest-precedence valid channel, wins.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (MODE == 1) begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (hold_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CH_W'(i);
                end
            end
        end else begin
            // Precedence order is ptr+1, ptr+2, ... wrapping, ptr last.
            for (int i = CHANNELS; i >= 1; i--) begin
                idx = int'(rr_ptr_reg) + i;
                if (idx >= CHANNELS) begin
                    idx = idx - CHANNELS;
                end
                if (hold_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CH_W'(idx);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Drop counter: all drops of one cycle are added at once, saturating.
    // -----------------------------------------------------------------------
    always_comb begin
        drop_total = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            drop_total = drop_total + CNT_W'(drop[i]);
        end
        drop_sum      = {1'b0, drop_cnt_reg} + 17'(drop_total);
        drop_cnt_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // -----------------------------------------------------------------------
    // FSM: next state and registered write-port outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        we_next        = 1'b0;
        addr_next      = addr_reg;
        data_next      = data_reg;
        grant_ch_next  = grant_ch_reg;
        busy_next      = busy_reg;
        clr_cnt_next   = clr_cnt_reg;
        clr_color_next = clr_color_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_fire     = 1'b0;

        case (state_reg)
            ST_ARB: begin
                // A clear takes precedence over a pending grant; the hold
                // survives and is written after the sweep, over the clear.
                if (i_clear) begin
                    state_next     = ST_CLEAR;
                    clr_color_next = i_clear_color;
                    clr_cnt_next   = '0;
                    busy_next      = 1'b1;
                end else if (i_enable && grant_valid) begin
                    grant_fire    = 1'b1;
                    we_next       = 1'b1;
                    addr_next     = hold_addr[grant_idx];
                    data_next     = hold_data[grant_idx];
                    grant_ch_next = grant_idx;
                    if (MODE == 0) begin
                        rr_ptr_next = grant_idx;
                    end
                end
            end

            ST_CLEAR: begin
                if (i_enable) begin
                    we_next       = 1'b1;
                    addr_next     = clr_cnt_reg;
                    data_next     = clr_color_reg;
                    grant_ch_next = '0;
                    // Leave on the edge that writes the last word so the
                    // counter never presents DEPTH on the bus.
                    if (clr_cnt_reg == LAST_ADDR) begin
                        state_next = ST_ARB;
                        busy_next  = 1'b0;
                    end else begin
                        clr_cnt_next = clr_cnt_reg + ADDR_WIDTH'(1);
                    end
                end
            end

            default: begin
                state_next = ST_ARB;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_ARB;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            data_reg      <= '0;
            grant_ch_reg  <= '0;
            busy_reg      <= 1'b0;
            drop_cnt_reg  <= '0;
            clr_cnt_reg   <= '0;
            clr_color_reg <= '0;
            // Pointer at the last channel so channel 0 is searched first.
            rr_ptr_reg    <= CH_W'(CHANNELS - 1);
        end else begin
            state_reg     <= state_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            data_reg      <= data_next;
            grant_ch_reg  <= grant_ch_next;
            busy_reg      <= busy_next;
            drop_cnt_reg  <= drop_cnt_next;
            clr_cnt_reg   <= clr_cnt_next;
            clr_color_reg <= clr_color_next;
            rr_ptr_reg    <= rr_ptr_next;
        end
    end

    assign o_we       = we_reg;
    assign o_addr     = addr_reg;
    assign o_data     = data_reg;
    assign o_grant_ch = grant_ch_reg;
    assign o_busy     = busy_reg;
    assign o_drop_cnt = drop_cnt_reg;

endmodule
